rr_arb_mux_4_1: RTL and testbench
=================================

RR_ARB_MUX_4_1 -- requirements
Module: rr_arb_mux_4_1

Interface
REQ-001 The block SHALL have parameter W, default 4, giving the data width of every data port.
REQ-002 The block SHALL have clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have rst, input, 1, an asynchronous active-high reset.
REQ-004 The block SHALL have up_valid, input, 4, where bit i means channel i presents data.
REQ-005 The block SHALL have d0, d1, d2, d3, input, W each, carrying the channel 0..3 data.
REQ-006 The block SHALL have up_ready, output, 4, where bit i means channel i data is accepted this cycle.
REQ-007 The block SHALL have down_valid, output, 1, meaning the output register holds a word.
REQ-008 The block SHALL have y, output, W, carrying the registered selected data.
REQ-009 The block SHALL have sel, output, 2, giving the channel index that produced y.
REQ-010 The block SHALL have down_ready, input, 1, meaning the consumer accepts y this cycle.

Function
REQ-011 The block SHALL keep a 2-bit pointer last holding the most recently granted channel.
REQ-012 The search order SHALL be last+1, last+2, last+3, last+4 (mod 4); the first channel with up_valid set is the candidate.
REQ-013 The load enable SHALL be load = (!down_valid || down_ready) && |up_valid.
REQ-014 up_ready SHALL be one-hot on the candidate when load is 1, else 4'b0000.
REQ-015 up_ready SHALL be combinational from up_valid, last, down_valid and down_ready, with no dependency on data.
REQ-016 On load, at the next edge: y <= candidate data, sel <= candidate index, down_valid <= 1, last <= candidate index.
REQ-017 Latency SHALL be exactly 1 cycle from the upstream handshake to down_valid.
REQ-018 Sustained throughput SHALL be 1 word per cycle while down_ready is held at 1.
REQ-019 Stall: when down_valid=1 and down_ready=0, y, sel, down_valid and last SHALL hold, and up_ready SHALL be 0.
REQ-020 Drain: when down_valid=1, down_ready=1 and up_valid=0, down_valid SHALL clear next cycle, and y and sel SHALL hold their old values.
REQ-021 Simultaneous consume and load SHALL overwrite the register in the same cycle with no bubble.
REQ-022 The pointer SHALL wrap from 3 to 0 modulo 4 with no special case.
REQ-023 A channel whose up_valid drops before its grant SHALL simply lose eligibility; no error or state change SHALL result.
REQ-024 Fairness: with all four channels continuously valid, each channel SHALL be granted exactly once in any 4 consecutive loads.
REQ-025 The block SHALL generate no latches; all combinational paths SHALL be fully assigned, including the default case.

Reset
REQ-026 While rst=1: down_valid=0, y=0, sel=0, last=3 (so channel 0 has first priority), and up_ready SHALL be 0.
REQ-027 Reset asserted mid-transfer SHALL discard the held word immediately, with no handshake completion reported.
REQ-028 The first edge after rst deasserts SHALL be able to load.

Verification
REQ-029 After reset, up_valid=4'b1111 and down_ready=1 held for 8 cycles -> sel sequence 0,1,2,3,0,1,2,3 with y matching d0..d3.
REQ-030 up_valid=4'b0100, d2=4'hA, down_ready=1 -> up_ready=4'b0100 in the same cycle; next cycle down_valid=1, y=4'hA, sel=2.
REQ-031 With down_valid=1 and y=4'h5 held, down_ready=0 for 3 cycles while up_valid=4'b1111 -> y=4'h5 is stable, up_ready=0 throughout, and last is unchanged.
REQ-032 With last=3, up_valid=4'b1001 -> grant channel 0, then channel 3, then channel 0 (wrap-around check).
REQ-033 Assert rst while down_valid=1 and down_ready=0 -> down_valid, y and sel go to 0 asynchronously before the next edge, and channel 0 is granted first afterwards.
REQ-034 up_valid=0 with down_valid=1 and down_ready=1 -> down_valid=0 next cycle, y unchanged, and no up_ready pulse.

Source files
------------

// File: rtl/rr_arb_mux_4_1.sv
// Four-channel round-robin arbiter feeding a single registered output stage.
// The search starts just after the last granted channel, so every channel gets a turn.
module rr_arb_mux_4_1 #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   up_valid,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  output logic [3:0]   up_ready,
  output logic         down_valid,
  output logic [W-1:0] y,
  output logic [1:0]   sel,
  input  logic         down_ready
);

  logic [1:0]   last;
  logic [1:0]   cand;
  logic [1:0]   idx;
  logic         found;
  logic         load;
  logic [W-1:0] cand_d;

  // The offset wraps in 2 bits, so the fourth probe lands back on last itself.
  always_comb begin
    cand  = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= 4; k++) begin
      idx = last + k[1:0];
      if (!found && up_valid[idx]) begin
        found = 1'b1;
        cand  = idx;
      end
    end
  end

  assign load     = (!down_valid || down_ready) && found && !rst;
  assign up_ready = load ? (4'b0001 << cand) : '0;

  always_comb begin
    cand_d = '0;
    case (cand)
      2'd0:    cand_d = d0;
      2'd1:    cand_d = d1;
      2'd2:    cand_d = d2;
      default: cand_d = d3;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      down_valid <= 1'b0;
      y          <= '0;
      sel        <= '0;
      last       <= 2'd3;
    end else if (load) begin
      down_valid <= 1'b1;
      y          <= cand_d;
      sel        <= cand;
      last       <= cand;
    end else if (down_ready) begin
      down_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_arb_mux_4_1.sv
// Self-checking bench for rr_arb_mux_4_1: directed scenarios plus a randomized run
// against a behavioural round-robin model.
module tb_rr_arb_mux_4_1;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   up_valid;
  logic [W-1:0] d0, d1, d2, d3;
  logic [3:0]   up_ready;
  logic         down_valid;
  logic [W-1:0] y;
  logic [1:0]   sel;
  logic         down_ready;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int           m_last;
  logic         m_dv;
  logic [W-1:0] m_y;
  int           m_sel;

  rr_arb_mux_4_1 #(.W(W)) dut (
    .clk(clk), .rst(rst), .up_valid(up_valid),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .up_ready(up_ready), .down_valid(down_valid), .y(y), .sel(sel),
    .down_ready(down_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] dsel(int i);
    case (i)
      0:       return d0;
      1:       return d1;
      2:       return d2;
      default: return d3;
    endcase
  endfunction

  // Index of the channel the model would grant this cycle, or -1 for none.
  function automatic int model_grant(logic [3:0] uv, logic dr);
    if (m_dv && !dr) return -1;
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (m_last + k) % 4;
      if (uv[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [3:0] model_ready(logic [3:0] uv, logic dr);
    int g;
    g = model_grant(uv, dr);
    return (g < 0) ? 4'b0000 : (4'b0001 << g);
  endfunction

  task automatic model_reset();
    m_last = 3; m_dv = 1'b0; m_y = '0; m_sel = 0;
  endtask

  task automatic randomize_data();
    d0 = W'($urandom); d1 = W'($urandom); d2 = W'($urandom); d3 = W'($urandom);
  endtask

  // Clock one edge and move the model along with it; returns #1 after the edge.
  task automatic advance();
    int g;
    logic [W-1:0] gd;
    g = model_grant(up_valid, down_ready);
    gd = (g < 0) ? '0 : dsel(g);
    @(posedge clk);
    if (g >= 0) begin
      m_dv = 1'b1; m_y = gd; m_sel = g; m_last = g;
    end else if (down_ready) begin
      m_dv = 1'b0;
    end
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; up_valid = 4'b1111; down_ready = 1'b1;
    randomize_data();
    model_reset();
    #1;
    checks++;
    if (down_valid !== 1'b0 || y !== '0 || sel !== 2'd0 || up_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset: dv=%b y=%h sel=%0d up_ready=%b, required dv=0 y=0 sel=0 up_ready=0000",
               down_valid, y, sel, up_ready);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      up_valid = 4'b1111; down_ready = 1'b1;
      randomize_data();
      #1;
      checks++;
      if (up_ready !== (4'b0001 << (i % 4))) begin
        errors++;
        $display("FAIL rr_ready[%0d]: got %b, required %b", i, up_ready, 4'b0001 << (i % 4));
      end
      advance();
      checks++;
      if (down_valid !== 1'b1 || sel !== 2'(i % 4) || y !== m_y) begin
        errors++;
        $display("FAIL rr_out[%0d]: dv=%b sel=%0d y=%h, required dv=1 sel=%0d y=%h",
                 i, down_valid, sel, y, i % 4, m_y);
      end
    end
  endtask

  task automatic test_single();
    @(negedge clk);
    up_valid = 4'b0100; down_ready = 1'b1;
    randomize_data(); d2 = 4'hA;
    #1;
    checks++;
    if (up_ready !== 4'b0100) begin
      errors++;
      $display("FAIL single_ready: got %b, required 0100", up_ready);
    end
    advance();
    checks++;
    if (down_valid !== 1'b1 || y !== 4'hA || sel !== 2'd2) begin
      errors++;
      $display("FAIL single_out: dv=%b y=%h sel=%0d, required dv=1 y=a sel=2", down_valid, y, sel);
    end
  endtask

  task automatic test_stall();
    // last=2, so the all-valid load grants channel 3 carrying 5.
    @(negedge clk);
    up_valid = 4'b1111; down_ready = 1'b1;
    d0 = 4'h5; d1 = 4'h5; d2 = 4'h5; d3 = 4'h5;
    advance();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      up_valid = 4'b1111; down_ready = 1'b0;
      randomize_data();
      #1;
      checks++;
      if (up_ready !== 4'b0000) begin
        errors++;
        $display("FAIL stall_ready[%0d]: got %b, required 0000", i, up_ready);
      end
      advance();
      checks++;
      if (down_valid !== 1'b1 || y !== 4'h5 || sel !== 2'd3) begin
        errors++;
        $display("FAIL stall_hold[%0d]: dv=%b y=%h sel=%0d, required dv=1 y=5 sel=3",
                 i, down_valid, y, sel);
      end
    end
    @(negedge clk);
    down_ready = 1'b1;
    #1;
    checks++;
    if (up_ready !== 4'b0001) begin
      errors++;
      $display("FAIL stall_last: got %b, required 0001", up_ready);
    end
    advance();
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    up_valid = 4'b1111; down_ready = 1'b0;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (down_valid !== 1'b0 || y !== '0 || sel !== 2'd0 || up_ready !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset: dv=%b y=%h sel=%0d up_ready=%b, required all 0",
               down_valid, y, sel, up_ready);
    end
    @(negedge clk);
    rst = 1'b0; down_ready = 1'b1;
    randomize_data();
    #1;
    checks++;
    if (up_ready !== 4'b0001) begin
      errors++;
      $display("FAIL post_reset_ready: got %b, required 0001", up_ready);
    end
    advance();
    checks++;
    if (down_valid !== 1'b1 || sel !== 2'd0 || y !== m_y) begin
      errors++;
      $display("FAIL post_reset_out: dv=%b sel=%0d y=%h, required dv=1 sel=0 y=%h",
               down_valid, sel, y, m_y);
    end
  endtask

  task automatic test_wrap();
    int exp_sel [3] = '{0, 3, 0};
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      up_valid = 4'b1001; down_ready = 1'b1;
      randomize_data();
      advance();
      checks++;
      if (down_valid !== 1'b1 || sel !== 2'(exp_sel[i]) || y !== m_y) begin
        errors++;
        $display("FAIL wrap[%0d]: dv=%b sel=%0d y=%h, required dv=1 sel=%0d y=%h",
                 i, down_valid, sel, y, exp_sel[i], m_y);
      end
    end
  endtask

  task automatic test_drain();
    logic [W-1:0] old_y;
    logic [1:0]   old_sel;
    @(negedge clk);
    up_valid = 4'b0000; down_ready = 1'b1;
    old_y = y; old_sel = sel;
    #1;
    checks++;
    if (up_ready !== 4'b0000) begin
      errors++;
      $display("FAIL drain_ready: got %b, required 0000", up_ready);
    end
    advance();
    checks++;
    if (down_valid !== 1'b0 || y !== old_y || sel !== old_sel) begin
      errors++;
      $display("FAIL drain_out: dv=%b y=%h sel=%0d, required dv=0 y=%h sel=%0d",
               down_valid, y, sel, old_y, old_sel);
    end
  endtask

  task automatic test_random();
    logic [3:0] er;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      up_valid = 4'($urandom);
      down_ready = ($urandom_range(0, 3) != 0);
      randomize_data();
      #1;
      er = model_ready(up_valid, down_ready);
      checks++;
      if (up_ready !== er) begin
        errors++;
        $display("FAIL rand_ready[%0d]: got %b, required %b", i, up_ready, er);
      end
      advance();
      checks++;
      if (down_valid !== m_dv || (m_dv && (y !== m_y || sel !== 2'(m_sel)))) begin
        errors++;
        $display("FAIL rand_out[%0d]: dv=%b y=%h sel=%0d, required dv=%b y=%h sel=%0d",
                 i, down_valid, y, sel, m_dv, m_y, m_sel);
      end
    end
  endtask

  initial begin
    rst = 1'b0; up_valid = '0; down_ready = 1'b0;
    d0 = '0; d1 = '0; d2 = '0; d3 = '0;
    model_reset();
    test_reset();
    test_round_robin();
    test_single();
    test_stall();
    test_async_reset();
    test_wrap();
    test_drain();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
